// File: rtl/regfile_mp_sb.sv
// Multi-port register file with per-register busy scoreboard; entries cleared one per cycle after reset.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_mp_sb #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   parameter int NWR   = 1,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   output logic                ready,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                set_en,
   input  logic [AW-1:0]       set_addr
);

   typedef enum logic {INIT, READY} state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   state_t           state_q, state_d;
   logic [AW-1:0]    clr_idx;
   logic [XLEN-1:0]  mem [NREGS];
   logic [NREGS-1:0] busy;

   always_ff @(posedge clk) begin
      if (rst) state_q <= INIT;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         INIT:    if (clr_idx == LAST_IDX) state_d = READY;
         READY:   state_d = READY;
         default: state_d = INIT;
      endcase
   end

   assign ready = (state_q == READY);

   // Entry 0 is never stored; reads of it are forced to zero below.
   always_ff @(posedge clk) begin
      if (rst)
         clr_idx <= AW'(1);
      else if (state_q == INIT && clr_idx != LAST_IDX)
         clr_idx <= clr_idx + AW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == INIT) begin
            mem[clr_idx] <= '0;
         end else begin
            for (int j = 0; j < NWR; j++) begin
               if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
                  mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
            end
         end
      end
   end

   // Set is applied after the write-clears so a new producer wins over a retiring one.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else if (state_q == READY) begin
         for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
               busy[wr_addr[j*AW +: AW]] <= 1'b0;
         end
         if (set_en && set_addr != '0)
            busy[set_addr] <= 1'b1;
      end
   end

   always_comb begin
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;
      logic            b;
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < NRD; i++) begin
         a = rd_addr[i*AW +: AW];
         d = '0;
         b = 1'b0;
         if (ready && a != '0) begin
            d = mem[a];
            b = busy[a];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NWR; j++) begin
               if (wr_en[j] && wr_addr[j*AW +: AW] == a) begin
                  d = wr_data[j*XLEN +: XLEN];
                  b = set_en && (set_addr == a);
               end
            end
`endif
         end
         rd_data[i*XLEN +: XLEN] = d;
         rd_busy[i] = b;
      end
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Randomized and directed bench for regfile_mp_sb (NRD=2, NWR=2) against an array-based reference model.
module tb_regfile_mp_sb;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 2;
   localparam int NWR   = 2;
   localparam int AW    = 5;

   logic                clk = 1'b0;
   logic                rst;
   logic                ready;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic                set_en;
   logic [AW-1:0]       set_addr;

   int checks = 0;
   int errors = 0;

   logic [XLEN-1:0] m_mem  [NREGS];
   logic            m_busy [NREGS];
   bit              m_rdy = 1'b0;

   always #5 clk = ~clk;

   regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
      .clk(clk), .rst(rst), .ready(ready),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .set_en(set_en), .set_addr(set_addr)
   );

   function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
      logic [XLEN-1:0] v;
      if (!m_rdy || a == 0) return '0;
      v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++)
         if (wr_en[j] && wr_addr[j*AW +: AW] == a) v = wr_data[j*XLEN +: XLEN];
`endif
      return v;
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a);
      logic v;
      if (!m_rdy || a == 0) return 1'b0;
      v = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < NWR; j++)
         if (wr_en[j] && wr_addr[j*AW +: AW] == a) v = set_en && (set_addr == a);
`endif
      return v;
   endfunction

   task automatic idle();
      wr_en = '0; wr_addr = '0; wr_data = '0; set_en = 1'b0; set_addr = '0;
   endtask

   task automatic rand_inputs();
      for (int j = 0; j < NWR; j++) begin
         wr_en[j] = 1'($urandom_range(0, 1));
         wr_addr[j*AW +: AW] = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, NREGS-1));
         wr_data[j*XLEN +: XLEN] = $urandom;
      end
      for (int i = 0; i < NRD; i++)
         rd_addr[i*AW +: AW] = AW'($urandom_range(0, 1) != 0 ? $urandom_range(0, 7) : $urandom_range(0, NREGS-1));
      set_en = 1'($urandom_range(0, 1));
      set_addr = AW'($urandom_range(0, 7));
   endtask

   // Advance one edge, updating the reference model from the inputs presented in this cycle.
   task automatic tick();
      if (m_rdy) begin
         for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] != 0) begin
               m_mem[wr_addr[j*AW +: AW]]  = wr_data[j*XLEN +: XLEN];
               m_busy[wr_addr[j*AW +: AW]] = 1'b0;
            end
         end
         if (set_en && set_addr != 0) m_busy[set_addr] = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      rd_addr = {AW'(0), AW'(5)};
      rst = 1'b1;
      tick();
      checks++;
      if (ready !== 1'b0 || rd_busy !== '0 || rd_data !== '0) begin
         errors++;
         $display("FAIL reset_state ready=%b busy=%b data=%h want 0/0/0", ready, rd_busy, rd_data);
      end
      rst = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         if (k < 32) rand_inputs(); else idle();
         rd_addr[AW-1:0] = AW'(5);
         #1;
         checks++;
         if (ready !== (k == 32)) begin
            errors++;
            $display("FAIL init_ready cycle %0d got %b want %b", k, ready, (k == 32));
         end
         if (k < 32) begin
            checks++;
            if (rd_data !== '0 || rd_busy !== '0) begin
               errors++;
               $display("FAIL init_reads cycle %0d data=%h busy=%b want 0", k, rd_data, rd_busy);
            end
            tick();
         end
      end
      idle();
      for (int r = 0; r < NREGS; r++) begin
         rd_addr = {AW'(r), AW'(r)};
         #1;
         checks++;
         if (rd_data !== '0 || rd_busy !== '0) begin
            errors++;
            $display("FAIL cleared_entry x%0d data=%h busy=%b want 0", r, rd_data, rd_busy);
         end
      end
   endtask

   task automatic test_reset_mid();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         checks++;
         if (ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_pre_ready cycle %0d got %b want 0", k, ready);
         end
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         checks++;
         if (ready !== (k == 32)) begin
            errors++;
            $display("FAIL mid_ready cycle %0d got %b want %b", k, ready, (k == 32));
         end
         if (k < 32) tick();
      end
      for (int r = 0; r < NREGS; r++) begin
         m_mem[r] = '0;
         m_busy[r] = 1'b0;
      end
      m_rdy = 1'b1;
   endtask

   task automatic test_bypass();
      idle();
      rd_addr = {AW'(9), AW'(9)};
      wr_en = 2'b01; wr_addr[AW-1:0] = AW'(9); wr_data[XLEN-1:0] = 32'hDEADBEEF;
      #1;
      checks++;
`ifdef REGFILE_BYPASS_EN
      if (rd_data[XLEN-1:0] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL bypass_same_cycle got %h want deadbeef", rd_data[XLEN-1:0]);
      end
`else
      if (rd_data[XLEN-1:0] !== 32'h0) begin
         errors++;
         $display("FAIL bypass_same_cycle got %h want 00000000", rd_data[XLEN-1:0]);
      end
`endif
      tick();
      idle();
      #1;
      checks++;
      if (rd_data[2*XLEN-1:XLEN] !== 32'hDEADBEEF || rd_busy !== '0) begin
         errors++;
         $display("FAIL bypass_next_cycle got %h busy=%b want deadbeef/0", rd_data[2*XLEN-1:XLEN], rd_busy);
      end
   endtask

   task automatic test_dual_write();
      idle();
      wr_en = 2'b11;
      wr_addr = {AW'(7), AW'(7)};
      wr_data = {32'h5555FFFF, 32'hAAAA0000};
      tick();
      idle();
      rd_addr = {AW'(7), AW'(7)};
      #1;
      checks++;
      if (rd_data !== {32'h5555FFFF, 32'h5555FFFF}) begin
         errors++;
         $display("FAIL dual_write_x7 got %h want 5555ffff on both ports", rd_data);
      end
   endtask

   task automatic test_x0();
      idle();
      rd_addr = '0;
      wr_en = 2'b01; wr_data[XLEN-1:0] = 32'hFFFFFFFF;
      set_en = 1'b1;
      #1;
      checks++;
      if (rd_data !== '0 || rd_busy !== '0) begin
         errors++;
         $display("FAIL x0_same_cycle data=%h busy=%b want 0", rd_data, rd_busy);
      end
      tick();
      idle();
      #1;
      checks++;
      if (rd_data !== '0 || rd_busy !== '0) begin
         errors++;
         $display("FAIL x0_after data=%h busy=%b want 0", rd_data, rd_busy);
      end
   endtask

   task automatic test_scoreboard();
      idle();
      rd_addr = {AW'(0), AW'(3)};
      set_en = 1'b1; set_addr = AW'(3);
      tick();
      idle();
      #1;
      checks++;
      if (rd_busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL sb_busy_c1 got %b want 1", rd_busy[0]);
      end
      tick();
      wr_en = 2'b01; wr_addr[AW-1:0] = AW'(3); wr_data[XLEN-1:0] = 32'h12345678;
      #1;
      checks++;
`ifdef REGFILE_BYPASS_EN
      if (rd_busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL sb_busy_c2 got %b want 0", rd_busy[0]);
      end
`else
      if (rd_busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL sb_busy_c2 got %b want 1", rd_busy[0]);
      end
`endif
      tick();
      idle();
      #1;
      checks++;
      if (rd_busy[0] !== 1'b0 || rd_data[XLEN-1:0] !== 32'h12345678) begin
         errors++;
         $display("FAIL sb_cleared busy=%b data=%h want 0/12345678", rd_busy[0], rd_data[XLEN-1:0]);
      end
      wr_en = 2'b10; wr_addr[2*AW-1:AW] = AW'(3); wr_data[2*XLEN-1:XLEN] = 32'h0BADF00D;
      set_en = 1'b1; set_addr = AW'(3);
      tick();
      idle();
      #1;
      checks++;
      if (rd_busy[0] !== 1'b1 || rd_data[XLEN-1:0] !== 32'h0BADF00D) begin
         errors++;
         $display("FAIL sb_set_wins busy=%b data=%h want 1/0badf00d", rd_busy[0], rd_data[XLEN-1:0]);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         rand_inputs();
         #1;
         for (int p = 0; p < NRD; p++) begin
            checks++;
            if (rd_data[p*XLEN +: XLEN] !== exp_data(rd_addr[p*AW +: AW]) ||
                rd_busy[p] !== exp_busy(rd_addr[p*AW +: AW])) begin
               errors++;
               $display("FAIL random_read n=%0d port%0d x%0d data=%h busy=%b want %h/%b", n, p,
                        rd_addr[p*AW +: AW], rd_data[p*XLEN +: XLEN], rd_busy[p],
                        exp_data(rd_addr[p*AW +: AW]), exp_busy(rd_addr[p*AW +: AW]));
            end
         end
         tick();
      end
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_terminal got %b want 1", ready);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      rd_addr = '0;
      idle();
      test_reset();
      test_reset_mid();
      test_bypass();
      test_dual_write();
      test_x0();
      test_scoreboard();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
